ha_response_checker: RTL and testbench
======================================

# ha_response_checker

Synthesizable response checker for the half_adder: the receiving end of the half_adder stimulus interface. It samples each applied input pair together with the DUT's sum/carry response and compares them against the expected result. It keeps pass/fail counts, captures the first failing vector, tracks coverage of the four input combinations and reports an overall verdict. It sits beside a half_adder instance, in simulation or on-chip self-test, and replaces manual waveform inspection.

## Interface
- CNT_W, 8, width of pass/fail counters; counters saturate at 2^CNT_W-1
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- clear  input  1  synchronous soft clear; same effect as rst, lower priority
- in_valid  input  1  qualifies in_a/in_b/in_sum/in_carry this cycle
- in_a  input  1  applied operand a
- in_b  input  1  applied operand b
- in_sum  input  1  DUT sum response
- in_carry  input  1  DUT carry response
- pass_count  output  CNT_W  matching vectors checked
- fail_count  output  CNT_W  mismatching vectors checked
- err  output  1  sticky; set on first mismatch
- first_fail  output  4  {a,b,sum,carry} of first mismatching vector
- coverage  output  4  bit {a,b} set once that input pair has been checked (pass or fail)
- state  output  2  00 IDLE, 01 RUN, 10 DONE, 11 FAIL
- done  output  1  high in DONE or FAIL

## Operation
- Stage 1: on an edge with in_valid=1, capture {in_a,in_b,in_sum,in_carry} into s1_vec and set s1_vld; otherwise s1_vld=0.
- Stage 2: when s1_vld=1, expected sum = a^b and expected carry = a&b. A match increments pass_count; a mismatch increments fail_count.
- On a mismatch with err=0: set err and load first_fail. Later mismatches leave first_fail unchanged.
- Each checked vector sets coverage[{a,b}].
- Counters saturate at all-ones. A saturated counter holds its value; the other counters keep updating.
- FSM, evaluated after the stage-2 update:
  - IDLE -> RUN on the first checked vector.
  - RUN -> FAIL when err becomes 1.
  - RUN -> DONE when coverage becomes 4'b1111 with err=0.
  - DONE -> FAIL if a later vector mismatches.
  - FAIL is absorbing until rst/clear.
  - In DONE and FAIL, checking continues: counters and coverage still update.
- If one vector both completes coverage and mismatches, the next state is FAIL. FAIL has priority over DONE.
- Reset/clear values: pass_count=0, fail_count=0, err=0, first_fail=4'b0000, coverage=4'b0000, state=IDLE, done=0, s1_vld=0.
- rst or clear asserted mid-run: the sample in stage 1 and any vector presented in the same cycle are discarded. No counter update follows.

## Timing
- A vector presented with in_valid=1 at edge N is captured at N. Its counters, err, first_fail, coverage and state are updated at edge N+1 and visible after N+1.
- Back-to-back in_valid is supported at one vector per cycle with no stalls. There is no backpressure.
- Each flag is registered and changes only at clock edges:
  - done = (state==DONE)||(state==FAIL).
  - err reflects a mismatch at the same edge as fail_count.
- If rst and clear are both high, rst applies. The two have identical effect.

## Test plan
- Exhaustive correct responses:
  - Stimulus: vectors (0,0,0,0), (0,1,1,0), (1,0,1,0), (1,1,0,1) on consecutive cycles.
  - Response: pass_count=4, fail_count=0, coverage=1111, state=DONE one edge after the last vector, err=0.
- Injected fault:
  - Stimulus: vector (1,1,sum=1,carry=1).
  - Response: fail_count=1, err=1, first_fail=4'b1111, state=FAIL.
  - Follow-on: a later bad vector (0,1,0,0) leaves first_fail=4'b1111 and gives fail_count=2.
- Gapped valid:
  - Stimulus: in_valid=0 cycles with garbage on the data inputs, interleaved with 3 good vectors.
  - Response: only 3 counted, coverage has exactly 3 bits set, state stays RUN.
- Saturation:
  - Stimulus: 300 good (0,0) vectors.
  - Response: pass_count=255 and holds, state=RUN, coverage=0001.
- Clear mid-stream:
  - Stimulus: clear in the cycle after a failing vector is captured, with a good vector presented in the same cycle.
  - Response: all outputs back to reset values, state=IDLE, neither vector counted.
- Simultaneous completion and fail:
  - Stimulus: after 3 good distinct pairs, the fourth pair (1,1) arrives with carry=0.
  - Response: state goes directly RUN->FAIL, coverage=1111, err=1.

Source files
------------

// File: rtl/ha_response_checker.sv
// ha_response_checker: two-stage half-adder response checker with counters, coverage and verdict FSM
module ha_response_checker #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic             in_a,
  input  logic             in_b,
  input  logic             in_sum,
  input  logic             in_carry,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             err,
  output logic [3:0]       first_fail,
  output logic [3:0]       coverage,
  output logic [1:0]       state,
  output logic             done
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10, FAIL = 2'b11} state_t;
  localparam logic [CNT_W-1:0] MAX = '1;
  logic             s1_vld_q, s1_vld_d;
  logic [3:0]       s1_vec_q, s1_vec_d;
  logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d;
  logic             err_q, err_d, done_q, done_d;
  logic [3:0]       ff_q, ff_d, cov_q, cov_d;
  state_t           state_q, state_d;
  logic             a, b, match, chk, mis;
  always_comb begin
    s1_vld_d = in_valid;
    s1_vec_d = in_valid ? {in_a, in_b, in_sum, in_carry} : s1_vec_q;
    a        = s1_vec_q[3];
    b        = s1_vec_q[2];
    match    = (s1_vec_q[1] == (a ^ b)) && (s1_vec_q[0] == (a & b));
    chk      = s1_vld_q;
    mis      = chk && !match;
    pass_d   = (chk && match && pass_q != MAX) ? pass_q + 1'b1 : pass_q;
    fail_d   = (mis && fail_q != MAX) ? fail_q + 1'b1 : fail_q;
    err_d    = err_q || mis;
    ff_d     = (mis && !err_q) ? s1_vec_q : ff_q;
    cov_d    = chk ? (cov_q | (4'b0001 << {a, b})) : cov_q;
    // FAIL outranks DONE when one vector both completes coverage and mismatches
    state_d  = (state_q == FAIL) ? FAIL :
               !chk              ? state_q :
               err_d             ? FAIL :
               (cov_d == 4'hf)   ? DONE : RUN;
    done_d   = (state_d == DONE) || (state_d == FAIL);
  end
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      s1_vld_q <= 1'b0;
      s1_vec_q <= '0;
      pass_q   <= '0;
      fail_q   <= '0;
      err_q    <= 1'b0;
      ff_q     <= '0;
      cov_q    <= '0;
      state_q  <= IDLE;
      done_q   <= 1'b0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_vec_q <= s1_vec_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      err_q    <= err_d;
      ff_q     <= ff_d;
      cov_q    <= cov_d;
      state_q  <= state_d;
      done_q   <= done_d;
    end
  end
  assign pass_count = pass_q;
  assign fail_count = fail_q;
  assign err        = err_q;
  assign first_fail = ff_q;
  assign coverage   = cov_q;
  assign state      = state_q;
  assign done       = done_q;
endmodule

// File: tb/tb_ha_response_checker.sv
// tb_ha_response_checker: directed vectors, expected snapshots queued by the driver and popped by a monitor
module tb_ha_response_checker;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_a = 1'b0, in_b = 1'b0, in_sum = 1'b0, in_carry = 1'b0;
  logic [7:0] pass_count, fail_count;
  logic       err, done;
  logic [3:0] first_fail, coverage;
  logic [1:0] state;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  typedef struct {int due; logic [27:0] v; string name;} exp_t;
  exp_t       q[$];
  string      tag = "init";
  logic [7:0] m_pass = 0, m_fail = 0;
  logic       m_err = 0;
  logic [3:0] m_ff = 0, m_cov = 0;
  logic [1:0] m_st = 0;

  ha_response_checker #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .in_sum(in_sum), .in_carry(in_carry),
    .pass_count(pass_count), .fail_count(fail_count), .err(err),
    .first_fail(first_fail), .coverage(coverage), .state(state), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic hchk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic push(input int due);
    exp_t e;
    e.due  = due;
    e.v    = {m_pass, m_fail, m_err, m_ff, m_cov, m_st, m_st[1]};
    e.name = tag;
    q.push_back(e);
  endtask

  task automatic vec(input logic a, input logic b, input logic s, input logic c);
    logic ok;
    @(posedge clk);
    #1;
    in_valid = 1'b1; in_a = a; in_b = b; in_sum = s; in_carry = c;
    ok = (s == (a ^ b)) && (c == (a & b));
    if (ok) begin
      if (m_pass != 8'hff) m_pass++;
    end else begin
      if (m_fail != 8'hff) m_fail++;
      if (!m_err) begin m_err = 1'b1; m_ff = {a, b, s, c}; end
    end
    m_cov[{a, b}] = 1'b1;
    if (m_st != 2'b11) m_st = m_err ? 2'b11 : (m_cov == 4'hf) ? 2'b10 : 2'b01;
    push(cyc + 2);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_a = 1'($urandom); in_b = 1'($urandom); in_sum = 1'($urandom); in_carry = 1'($urandom);
    end
  endtask

  // a good vector rides along with the reset and must be discarded
  task automatic do_reset(input bit use_rst);
    exp_t e;
    @(posedge clk);
    #1;
    if (use_rst) rst = 1'b1; else clear = 1'b1;
    in_valid = 1'b1; in_a = 1'b0; in_b = 1'b1; in_sum = 1'b1; in_carry = 1'b0;
    while (q.size() != 0 && q[q.size()-1].due >= cyc + 1) e = q.pop_back();
    m_pass = 0; m_fail = 0; m_err = 0; m_ff = 0; m_cov = 0; m_st = 0;
    push(cyc + 1);
    @(posedge clk);
    #1;
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (q.size() != 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.due < cyc) begin
        failures++;
        $display("FAIL %s missed snapshot due=%0d now=%0d", e.name, e.due, cyc);
      end else if ({pass_count, fail_count, err, first_fail, coverage, state, done} !== e.v) begin
        failures++;
        $display("FAIL %s snapshot actual=%07h required=%07h", e.name,
                 {pass_count, fail_count, err, first_fail, coverage, state, done}, e.v);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    hchk("reset_pass", pass_count, 0);
    hchk("reset_fail", fail_count, 0);
    hchk("reset_flags", {err, done, state, coverage, first_fail}, 0);

    tag = "exhaustive";
    vec(0, 0, 0, 0); vec(0, 1, 1, 0); vec(1, 0, 1, 0); vec(1, 1, 0, 1);
    idle(2);
    @(negedge clk);
    hchk("exh_pass", pass_count, 4);
    hchk("exh_fail", fail_count, 0);
    hchk("exh_cov", coverage, 4'hf);
    hchk("exh_state", state, 2'b10);
    hchk("exh_done_err", {done, err}, 2'b10);

    tag = "fault";
    do_reset(0);
    vec(1, 1, 1, 1);
    idle(2);
    @(negedge clk);
    hchk("fault_fail", fail_count, 1);
    hchk("fault_err", err, 1);
    hchk("fault_ff", first_fail, 4'hf);
    hchk("fault_state", state, 2'b11);
    vec(0, 1, 0, 0);
    idle(2);
    @(negedge clk);
    hchk("fault2_ff", first_fail, 4'hf);
    hchk("fault2_fail", fail_count, 2);

    tag = "gapped";
    do_reset(1);
    vec(0, 0, 0, 0); idle(2); vec(0, 1, 1, 0); idle(1); vec(1, 0, 1, 0); idle(3);
    @(negedge clk);
    hchk("gap_pass", pass_count, 3);
    hchk("gap_cov", coverage, 4'b0111);
    hchk("gap_state", state, 2'b01);

    tag = "saturate";
    do_reset(0);
    for (int i = 0; i < 300; i++) vec(0, 0, 0, 0);
    idle(2);
    @(negedge clk);
    hchk("sat_pass", pass_count, 255);
    hchk("sat_state", state, 2'b01);
    hchk("sat_cov", coverage, 4'b0001);

    tag = "clear_mid";
    vec(1, 1, 1, 1);
    do_reset(0);
    idle(2);
    @(negedge clk);
    hchk("clr_counts", {pass_count, fail_count}, 0);
    hchk("clr_flags", {err, done, state, coverage, first_fail}, 0);

    tag = "complete_fail";
    vec(0, 0, 0, 0); vec(0, 1, 1, 0); vec(1, 0, 1, 0); vec(1, 1, 0, 0);
    idle(2);
    @(negedge clk);
    hchk("cf_state", state, 2'b11);
    hchk("cf_cov", coverage, 4'hf);
    hchk("cf_err", err, 1);
    hchk("cf_ff", first_fail, 4'b1100);

    repeat (5) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
